// File: rtl/bsd_pkg.sv
// ---------------------------------------------------------------------------
// bsd_pkg
// Shared types for the binary-signed-digit accumulator.
//   state_t  : frame control states (ACC, CONV, OUT)
//   digit_t  : one signed digit as a (p,n) pair, value = p - n
//   DIG_*    : legal digit encodings; (1,1) is never produced
// No ports.
// ---------------------------------------------------------------------------
package bsd_pkg;

    typedef enum logic [1:0] {
        ACC  = 2'd0,
        CONV = 2'd1,
        OUT  = 2'd2
    } state_t;

    typedef struct packed {
        logic p;
        logic n;
    } digit_t;

    localparam digit_t DIG_ZERO = 2'b00;
    localparam digit_t DIG_POS  = 2'b10;
    localparam digit_t DIG_NEG  = 2'b01;

endpackage

// File: rtl/bsd_accumulator_if.sv
// ---------------------------------------------------------------------------
// bsd_accumulator_if
// Operand and result handshake bundle for bsd_accumulator.
//   in_valid/in_ready    operand handshake
//   in_data              two's-complement operand (WIDTH bits)
//   in_sub               1 = subtract, 0 = add
//   in_last              final operand of the frame
//   out_valid/out_ready  result handshake
//   out_sum              frame result, modulo 2^WIDTH
// master: producer/consumer side.  slave: the accumulator.
// ---------------------------------------------------------------------------
interface bsd_accumulator_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sub;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;

    modport master (
        output in_valid, in_data, in_sub, in_last, out_ready,
        input  in_ready, out_valid, out_sum
    );

    modport slave (
        input  in_valid, in_data, in_sub, in_last, out_ready,
        output in_ready, out_valid, out_sum
    );
endinterface

// File: rtl/bsd_digit_cell.sv
// ---------------------------------------------------------------------------
// bsd_digit_cell
// One position of the carry-free signed-digit adder/subtractor.
//   i_d     current digit
//   i_x     operand bit at this position
//   i_sub   1 = subtract operand, 0 = add
//   i_t_in  transfer magnitude from the next-lower position
//   o_t     transfer magnitude to the next-higher position
//   o_d     new digit
// Transfer sign is implied by the operation: +1 when adding, -1 when
// subtracting. The interim digit w has the opposite sign, so w + t_in always
// lands in {-1,0,+1} and o_t never depends on i_t_in (constant depth).
// ---------------------------------------------------------------------------
module bsd_digit_cell
    import bsd_pkg::*;
(
    input  digit_t i_d,
    input  logic   i_x,
    input  logic   i_sub,
    input  logic   i_t_in,
    output logic   o_t,
    output digit_t o_d
);
    logic w_w;
    logic w_pos;
    logic w_neg;

    // |w| = 1 exactly when z = d +/- x is odd.
    assign w_w = (i_d.p | i_d.n) ^ i_x;

    // Add: transfer when z >= 1.  Sub: transfer when z <= -1.
    assign o_t = i_sub ? (i_d.n | (i_x & ~i_d.p))
                       : (i_d.p | (i_x & ~i_d.n));

    // Add: digit = t_in - |w|.  Sub: digit = |w| - t_in.
    assign w_pos = i_sub ? (w_w & ~i_t_in) : (i_t_in & ~w_w);
    assign w_neg = i_sub ? (i_t_in & ~w_w) : (w_w & ~i_t_in);
    assign o_d   = '{p: w_pos, n: w_neg};
endmodule

// File: rtl/bsd_accumulator.sv
// ---------------------------------------------------------------------------
// bsd_accumulator
// Accumulates a frame of signed operands in carry-free signed-digit form, then
// converts the digits to two's complement CHUNK bits per cycle.
//   clk   clock, rising edge
//   rst   synchronous active-high reset
//   bus   bsd_accumulator_if.slave (operand in, result out)
// Parameters: WIDTH (digits/bits), CHUNK (bits converted per cycle).
// ---------------------------------------------------------------------------
module bsd_accumulator
    import bsd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic               clk,
    input logic               rst,
    bsd_accumulator_if.slave  bus
);
    localparam int NCH   = WIDTH / CHUNK;
    localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("bsd_accumulator: CHUNK must be >= 1 and divide WIDTH");
    end

    state_t                  r_state;
    state_t                  w_next_state;
    digit_t [WIDTH-1:0]      r_acc;
    digit_t [WIDTH-1:0]      w_acc_next;
    logic   [WIDTH-1:0]      w_t;
    logic   [WIDTH-1:0]      w_t_in;
    logic   [WIDTH-1:0]      r_sum;
    logic                    r_out_valid;
    logic                    r_borrow;
    logic   [CNT_W-1:0]      r_cnt;
    logic   [CHUNK-1:0]      w_p_chunk;
    logic   [CHUNK-1:0]      w_n_chunk;
    logic   [CHUNK:0]        w_diff;
    logic                    w_accept;
    logic                    w_conv_done;

    assign bus.in_ready  = (r_state == ACC);
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_sum;

    assign w_accept    = bus.in_valid && (r_state == ACC);
    assign w_conv_done = (r_cnt == CNT_W'(NCH - 1));

    // Transfer into each digit comes from the one below; the shift drops the
    // transfer out of the top digit, giving the modulo-2^WIDTH wrap.
    assign w_t_in = w_t << 1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        bsd_digit_cell u_cell (
            .i_d    (r_acc[i]),
            .i_x    (bus.in_data[i]),
            .i_sub  (bus.in_sub),
            .i_t_in (w_t_in[i]),
            .o_t    (w_t[i]),
            .o_d    (w_acc_next[i])
        );
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ACC;
        else     r_state <= w_next_state;
    end

    // NOTE: defaults first so no path through the block infers a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ACC:     if (w_accept && bus.in_last) w_next_state = CONV;
            CONV:    if (w_conv_done)             w_next_state = OUT;
            OUT:     if (bus.out_ready)           w_next_state = ACC;
            default:                              w_next_state = ACC;
        endcase
    end

    // Select the P and N bits of the chunk currently being resolved.
    always_comb begin
        w_p_chunk = '0;
        w_n_chunk = '0;
        for (int c = 0; c < NCH; c++) begin
            if (r_cnt == CNT_W'(c)) begin
                for (int b = 0; b < CHUNK; b++) begin
                    w_p_chunk[b] = r_acc[c*CHUNK + b].p;
                    w_n_chunk[b] = r_acc[c*CHUNK + b].n;
                end
            end
        end
    end

    // Top bit of the (CHUNK+1)-bit difference is the borrow into the next chunk.
    assign w_diff = {1'b0, w_p_chunk} - {1'b0, w_n_chunk} - {{CHUNK{1'b0}}, r_borrow};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= {WIDTH{DIG_ZERO}};
            r_sum       <= '0;
            r_out_valid <= 1'b0;
            r_borrow    <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_out_valid <= (w_next_state == OUT);
            unique case (r_state)
                ACC: begin
                    if (w_accept) r_acc <= w_acc_next;
                end
                CONV: begin
                    for (int c = 0; c < NCH; c++) begin
                        if (r_cnt == CNT_W'(c)) r_sum[c*CHUNK +: CHUNK] <= w_diff[CHUNK-1:0];
                    end
                    if (w_conv_done) begin
                        r_cnt    <= '0;
                        r_borrow <= 1'b0;
                    end else begin
                        r_cnt    <= r_cnt + 1'b1;
                        r_borrow <= w_diff[CHUNK];
                    end
                end
                OUT: begin
                    if (bus.out_ready) r_acc <= {WIDTH{DIG_ZERO}};
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bsd_accumulator.sv
// ---------------------------------------------------------------------------
// tb_bsd_accumulator
// Directed frames on a 16/4 instance, plus randomized frames on 16/4, 32/8 and
// 8/1 instances, each checked by a queue-based scoreboard against a plain
// modulo-2^WIDTH running sum.
// ---------------------------------------------------------------------------
module tb_bsd_accumulator;
    import bsd_pkg::*;

    localparam int N_OPS = 10000;

    logic clk;
    int   n_tests;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- directed instance (16/4) ----------------
    logic        d_rst;
    logic [15:0] d_model;
    logic [15:0] d_q[$];
    logic [15:0] d_exp;

    bsd_accumulator_if #(.WIDTH(16)) d_if ();
    bsd_accumulator #(.WIDTH(16), .CHUNK(4)) d_dut (
        .clk (clk),
        .rst (d_rst),
        .bus (d_if.slave)
    );

    // Monitor: a handshake happens on the next rising edge.
    always @(negedge clk) begin
        if (!d_rst && d_if.out_valid && d_if.out_ready) begin
            if (d_q.size() == 0) check("d_unexpected_out", 64'(1), 64'(0));
            else begin
                d_exp = d_q.pop_front();
                check("d_sum", 64'(d_if.out_sum), 64'(d_exp));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic d_send(input logic [15:0] data, input logic sub, input logic last);
        int k;
        d_if.in_valid = 1'b1;
        d_if.in_data  = data;
        d_if.in_sub   = sub;
        d_if.in_last  = last;
        k = 0;
        @(negedge clk);
        while (!d_if.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("d_accept", 64'(d_if.in_ready), 64'(1));
        d_model = sub ? d_model - data : d_model + data;
        if (last) begin
            d_q.push_back(d_model);
            d_model = '0;
        end
        @(posedge clk); #1;
        d_if.in_valid = 1'b0;
        d_if.in_last  = 1'b0;
    endtask

    // Result must appear exactly NCH=4 edges after the in_last acceptance.
    task automatic d_latency(input logic [15:0] exp);
        for (int i = 0; i < 4; i++) begin
            check("lat_early", 64'(d_if.out_valid), 64'(0));
            @(posedge clk); #1;
        end
        check("lat_valid", 64'(d_if.out_valid), 64'(1));
        check("lat_sum", 64'(d_if.out_sum), 64'(exp));
    endtask

    task automatic d_idle();
        int k;
        k = 0;
        while (!d_if.in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("idle_ready", 64'(d_if.in_ready), 64'(1));
    endtask

    // ---------------- random instances ----------------
    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int W = (g == 0) ? 16 : (g == 1) ? 32 : 8;
        localparam int C = (g == 0) ? 4  : (g == 1) ? 8  : 1;

        logic         rst;
        logic         done;
        logic [W-1:0] model;
        logic [W-1:0] q[$];
        logic [W-1:0] m_exp;
        logic         bad;
        digit_t       dig;
        int           acc_cnt;

        bsd_accumulator_if #(.WIDTH(W)) bus ();
        bsd_accumulator #(.WIDTH(W), .CHUNK(C)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );

        always @(negedge clk) begin
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) check("rnd_unexpected_out", 64'(1), 64'(0));
                else begin
                    m_exp = q.pop_front();
                    check("rnd_sum", 64'(bus.out_sum), 64'(m_exp));
                end
            end
        end

        // Every accumulator digit must be one of the three legal encodings.
        always @(negedge clk) begin
            if (!rst) begin
                bad = 1'b0;
                for (int i = 0; i < W; i++) begin
                    dig = dut.r_acc[i];
                    if (dig != DIG_ZERO && dig != DIG_POS && dig != DIG_NEG) bad = 1'b1;
                end
                check("digit_legal", 64'(bad), 64'(0));
            end
        end

        initial begin
            done          = 1'b0;
            rst           = 1'b1;
            model         = '0;
            acc_cnt       = 0;
            bus.in_valid  = 1'b0;
            bus.in_data   = '0;
            bus.in_sub    = 1'b0;
            bus.in_last   = 1'b0;
            bus.out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            while (acc_cnt < N_OPS) begin
                bus.in_valid  = ($urandom_range(0, 3) != 0);
                bus.in_data   = W'($urandom);
                bus.in_sub    = 1'($urandom_range(0, 1));
                bus.in_last   = ($urandom_range(0, 7) == 0);
                bus.out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (bus.in_valid && bus.in_ready) begin
                    model = bus.in_sub ? model - bus.in_data : model + bus.in_data;
                    if (bus.in_last) begin
                        q.push_back(model);
                        model = '0;
                    end
                    acc_cnt++;
                end
                @(posedge clk); #1;
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            for (int c = 0; c < 200 && q.size() != 0; c++) @(posedge clk);
            check("rnd_drain", 64'(q.size()), 64'(0));
            done = 1'b1;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        n_tests        = 0;
        n_fail         = 0;
        d_model        = '0;
        d_rst          = 1'b1;
        d_if.in_valid  = 1'b0;
        d_if.in_data   = '0;
        d_if.in_sub    = 1'b0;
        d_if.in_last   = 1'b0;
        d_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 d_rst = 1'b0;

        check("rst_out_valid", 64'(d_if.out_valid), 64'(0));
        check("rst_out_sum", 64'(d_if.out_sum), 64'(0));
        check("rst_in_ready", 64'(d_if.in_ready), 64'(1));

        // Basic addition and latency.
        d_send(16'h1234, 1'b0, 1'b0);
        d_send(16'h0FFF, 1'b0, 1'b1);
        d_latency(16'h2233);
        d_idle();

        // Add then subtract to a negative result, then wrap to zero.
        d_send(16'h0005, 1'b0, 1'b0);
        d_send(16'h0007, 1'b1, 1'b1);
        d_latency(16'hFFFE);
        d_idle();
        d_send(16'hFFFF, 1'b0, 1'b0);
        d_send(16'h0001, 1'b0, 1'b1);
        d_latency(16'h0000);
        d_idle();

        // Back-pressure in OUT with a competing operand on the input.
        d_if.out_ready = 1'b0;
        d_send(16'h00A5, 1'b1, 1'b1);
        d_latency(16'hFF5B);
        d_if.in_valid = 1'b1;
        d_if.in_data  = 16'h7777;
        d_if.in_sub   = 1'b0;
        d_if.in_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(d_if.out_valid), 64'(1));
            check("hold_sum", 64'(d_if.out_sum), 64'(16'hFF5B));
            check("hold_in_ready", 64'(d_if.in_ready), 64'(0));
        end
        d_if.in_valid  = 1'b0;
        d_if.in_last   = 1'b0;
        d_if.out_ready = 1'b1;
        d_idle();
        d_send(16'h0003, 1'b0, 1'b1);
        d_latency(16'h0003);
        d_idle();

        // Reset on the second CONV cycle aborts the frame.
        d_send(16'h0100, 1'b0, 1'b1);
        @(posedge clk); #1;
        d_rst = 1'b1;
        @(posedge clk); #1;
        d_rst = 1'b0;
        d_q.delete();
        check("abort_in_ready", 64'(d_if.in_ready), 64'(1));
        check("abort_out_sum", 64'(d_if.out_sum), 64'(0));
        for (int i = 0; i < 8; i++) begin
            check("abort_no_valid", 64'(d_if.out_valid), 64'(0));
            @(posedge clk); #1;
        end
        d_send(16'h0001, 1'b1, 1'b1);
        d_latency(16'hFFFF);
        d_idle();
        check("d_drain", 64'(d_q.size()), 64'(0));

        for (int c = 0; c < 60000 && !(cfg[0].done && cfg[1].done && cfg[2].done); c++)
            @(posedge clk);
        check("rnd_complete", 64'(cfg[0].done && cfg[1].done && cfg[2].done), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
